brick_field: RTL and testbench

BRICK_FIELD -- requirements
Module: brick_field

---
 rtl/brick_field.sv | 219 +++++++++++++++++++++
 tb/tb_brick_field.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/brick_field.sv
// Row of destructible bricks: per pass, hit-test the ball against each brick, then
// erase, optionally lower, and redraw it through a pixel-serial VGA plot interface.
module brick_field #(
    parameter int unsigned NUM_BLOCKS = 5,
    parameter int unsigned BLOCK_W    = 8,
    parameter int unsigned BLOCK_H    = 2,
    parameter int unsigned X_START    = 15,
    parameter int unsigned X_PITCH    = 30,
    parameter int unsigned Y_START    = 30,
    parameter int unsigned DROP_STEP  = 10,
    parameter int unsigned MAX_HITS   = 3,
    parameter int unsigned DEAD_LINE  = 108
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              lower,
    input  logic [7:0]                        ball_x,
    input  logic [7:0]                        ball_y,
    output logic                              busy,
    output logic                              done,
    output logic                              bounce,
    output logic [7:0]                        x,
    output logic [7:0]                        y,
    output logic [2:0]                        colour,
    output logic                              plot,
    output logic [$clog2(NUM_BLOCKS+1)-1:0]   blocks_left,
    output logic                              overrun
);

    localparam int unsigned IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int unsigned COL_W = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
    localparam int unsigned ROW_W = (BLOCK_H > 1) ? $clog2(BLOCK_H) : 1;
    localparam int unsigned BL_W  = $clog2(NUM_BLOCKS + 1);
    localparam int unsigned Y_MAX = 120 - BLOCK_H;

    if (NUM_BLOCKS < 1 || NUM_BLOCKS > 16) begin : g_bad_num
        $error("NUM_BLOCKS must be 1..16");
    end
    if (MAX_HITS < 1 || MAX_HITS > 7) begin : g_bad_hits
        $error("MAX_HITS must be 1..7");
    end
    if (X_START + (NUM_BLOCKS - 1) * X_PITCH + BLOCK_W - 1 > 159) begin : g_bad_x
        $error("brick row extends past x=159");
    end

    typedef enum logic [2:0] {StIdle, StCheck, StErase, StMove, StDraw, StFinish} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [COL_W-1:0]  col_q, col_d, col_nxt;
    logic [ROW_W-1:0]  row_q, row_d, row_nxt;
    logic [7:0]        bx_q, bx_d, by_q, by_d;
    logic              lower_q, lower_d, hit_q, hit_d;
    logic [2:0]        health_q [NUM_BLOCKS];
    logic [2:0]        health_d [NUM_BLOCKS];
    logic [7:0]        ypos_q [NUM_BLOCKS];
    logic [7:0]        ypos_d [NUM_BLOCKS];
    logic [BL_W-1:0]   blocks_left_q, blocks_left_d;
    logic              overrun_q, overrun_d;

    logic [2:0] cur_health, cur_colour;
    logic [8:0] cur_x, cur_y, drop_y;
    logic       hit_now, scan_last;

    always_comb begin
        cur_health = health_q[idx_q];
        cur_x      = 9'(X_START) + 9'(idx_q) * 9'(X_PITCH);
        cur_y      = {1'b0, ypos_q[idx_q]};
        drop_y     = cur_y + 9'(DROP_STEP);
        hit_now    = (cur_health != 3'd0) &&
                     ({1'b0, bx_q} >= cur_x) && ({1'b0, bx_q} <= cur_x + 9'(BLOCK_W - 1)) &&
                     ({1'b0, by_q} >= cur_y) && ({1'b0, by_q} <= cur_y + 9'(BLOCK_H - 1));
        case (cur_health)
            3'd0:    cur_colour = 3'b000;
            3'd1:    cur_colour = 3'b100;
            3'd2:    cur_colour = 3'b110;
            default: cur_colour = 3'b010;
        endcase

        // Row-major rectangle scan shared by erase and draw.
        scan_last = (col_q == COL_W'(BLOCK_W - 1)) && (row_q == ROW_W'(BLOCK_H - 1));
        if (col_q == COL_W'(BLOCK_W - 1)) begin
            col_nxt = '0;
            row_nxt = (row_q == ROW_W'(BLOCK_H - 1)) ? '0 : row_q + 1'b1;
        end else begin
            col_nxt = col_q + 1'b1;
            row_nxt = row_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        col_d    = col_q;
        row_d    = row_q;
        bx_d     = bx_q;
        by_d     = by_q;
        lower_d  = lower_q;
        hit_d    = hit_q;
        health_d = health_q;
        ypos_d   = ypos_q;
        plot     = 1'b0;
        x        = 8'd0;
        y        = 8'd0;
        colour   = 3'b000;
        done     = 1'b0;
        bounce   = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    bx_d    = ball_x;
                    by_d    = ball_y;
                    lower_d = lower;
                    hit_d   = 1'b0;
                    idx_d   = '0;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (hit_now) begin
                    health_d[idx_q] = cur_health - 3'd1;
                    hit_d           = 1'b1;
                end
                col_d   = '0;
                row_d   = '0;
                state_d = StErase;
            end
            StErase: begin
                plot  = 1'b1;
                x     = cur_x[7:0] + 8'(col_q);
                y     = cur_y[7:0] + 8'(row_q);
                col_d = col_nxt;
                row_d = row_nxt;
                if (scan_last) state_d = StMove;
            end
            StMove: begin
                if (lower_q && cur_health != 3'd0) begin
                    ypos_d[idx_q] = (drop_y > 9'(Y_MAX)) ? 8'(Y_MAX) : drop_y[7:0];
                end
                state_d = StDraw;
            end
            StDraw: begin
                plot   = 1'b1;
                x      = cur_x[7:0] + 8'(col_q);
                y      = cur_y[7:0] + 8'(row_q);
                colour = cur_colour;
                col_d  = col_nxt;
                row_d  = row_nxt;
                if (scan_last) begin
                    if (idx_q == IDX_W'(NUM_BLOCKS - 1)) begin
                        state_d = StFinish;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StCheck;
                    end
                end
            end
            StFinish: begin
                done    = 1'b1;
                bounce  = hit_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Status lags brick state by one cycle; the last update settles long before done.
    always_comb begin
        blocks_left_d = '0;
        overrun_d     = 1'b0;
        for (int i = 0; i < int'(NUM_BLOCKS); i++) begin
            if (health_q[i] != 3'd0) begin
                blocks_left_d = blocks_left_d + BL_W'(1);
                if ({1'b0, ypos_q[i]} + 9'(BLOCK_H - 1) >= 9'(DEAD_LINE)) overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            col_q         <= '0;
            row_q         <= '0;
            bx_q          <= 8'd0;
            by_q          <= 8'd0;
            lower_q       <= 1'b0;
            hit_q         <= 1'b0;
            blocks_left_q <= BL_W'(NUM_BLOCKS);
            overrun_q     <= 1'b0;
            for (int i = 0; i < int'(NUM_BLOCKS); i++) begin
                health_q[i] <= 3'(MAX_HITS);
                ypos_q[i]   <= 8'(Y_START);
            end
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            col_q         <= col_d;
            row_q         <= row_d;
            bx_q          <= bx_d;
            by_q          <= by_d;
            lower_q       <= lower_d;
            hit_q         <= hit_d;
            blocks_left_q <= blocks_left_d;
            overrun_q     <= overrun_d;
            health_q      <= health_d;
            ypos_q        <= ypos_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign blocks_left = blocks_left_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_brick_field.sv
// Bench for brick_field: a brick-level model predicts each pass's pixel stream and
// status; directed scenarios plus randomized ball positions are compared against it.
module tb_brick_field;

    logic       clock = 1'b0;
    logic       reset, start, lower;
    logic [7:0] ball_x, ball_y;
    logic       busy, done, bounce, plot, overrun;
    logic [7:0] x, y;
    logic [2:0] colour;
    logic [2:0] blocks_left;

    int checks = 0;
    int failures = 0;

    int          m_health [5];
    int          m_y [5];
    logic [18:0] exp_q [$];
    int          exp_bounce, exp_left, exp_over;

    brick_field dut (
        .clock(clock), .reset(reset), .start(start), .lower(lower),
        .ball_x(ball_x), .ball_y(ball_y), .busy(busy), .done(done), .bounce(bounce),
        .x(x), .y(y), .colour(colour), .plot(plot), .blocks_left(blocks_left),
        .overrun(overrun)
    );

    always #5 clock = ~clock;

    initial begin
        #10000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic int colour_of(input int h);
        if (h == 0) return 0;
        if (h == 1) return 4;
        if (h == 2) return 6;
        return 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            m_health[i] = 3;
            m_y[i] = 30;
        end
    endtask

    // Whole-pass prediction: hit-test, erase at old y, lower, draw at new y.
    task automatic model_pass(input int bx, input int by, input bit lw);
        int xi;
        exp_q.delete();
        exp_bounce = 0;
        for (int i = 0; i < 5; i++) begin
            xi = 15 + 30 * i;
            if (m_health[i] > 0 && bx >= xi && bx <= xi + 7 && by >= m_y[i] && by <= m_y[i] + 1) begin
                m_health[i]--;
                exp_bounce = 1;
            end
            for (int k = 0; k < 16; k++) exp_q.push_back({8'(xi + k % 8), 8'(m_y[i] + k / 8), 3'd0});
            if (lw && m_health[i] > 0) m_y[i] = (m_y[i] + 10 > 118) ? 118 : m_y[i] + 10;
            for (int k = 0; k < 16; k++)
                exp_q.push_back({8'(xi + k % 8), 8'(m_y[i] + k / 8), 3'(colour_of(m_health[i]))});
        end
        exp_left = 0;
        exp_over = 0;
        for (int i = 0; i < 5; i++) begin
            if (m_health[i] > 0) begin
                exp_left++;
                if (m_y[i] + 1 >= 108) exp_over = 1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
        model_reset();
    endtask

    // Runs one pass and checks it cycle by cycle; poke>0 re-asserts start mid-pass.
    task automatic run_pass(input int bx, input int by, input bit lw, input int poke,
                            output int got_bounce);
        int cyc, p;
        bit seen;
        model_pass(bx, by, lw);
        got_bounce = -1;
        @(negedge clock);
        ball_x = 8'(bx);
        ball_y = 8'(by);
        lower = lw;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 1;
        p = 0;
        seen = 0;
        while (cyc <= 400 && !seen) begin
            if (cyc == poke) begin
                start = 1'b1;
                ball_x = 8'd18;
                ball_y = 8'd31;
                lower = 1'b1;
            end else begin
                start = 1'b0;
            end
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL busy cyc=%0d got=%b exp=1", cyc, busy);
            end
            checks++;
            if (plot === 1'b1) begin
                if (p >= exp_q.size() || {x, y, colour} !== exp_q[p]) begin
                    failures++;
                    $display("FAIL pixel %0d got x=%0d y=%0d c=%b exp=%h", p, x, y, colour,
                             (p < exp_q.size()) ? exp_q[p] : 19'h0);
                end
                p++;
            end else if ({x, y, colour} !== 19'd0) begin
                failures++;
                $display("FAIL idle_xyc cyc=%0d got=%h exp=0", cyc, {x, y, colour});
            end
            if (done === 1'b1) begin
                seen = 1;
                got_bounce = int'(bounce);
                checks++;
                if (bounce !== 1'(exp_bounce)) begin
                    failures++;
                    $display("FAIL bounce got=%b exp=%0d", bounce, exp_bounce);
                end
                checks++;
                if (blocks_left !== 3'(exp_left)) begin
                    failures++;
                    $display("FAIL blocks_left got=%0d exp=%0d", blocks_left, exp_left);
                end
                checks++;
                if (overrun !== 1'(exp_over)) begin
                    failures++;
                    $display("FAIL overrun got=%b exp=%0d", overrun, exp_over);
                end
            end else begin
                checks++;
                if (bounce !== 1'b0) begin
                    failures++;
                    $display("FAIL bounce_early cyc=%0d got=%b exp=0", cyc, bounce);
                end
                @(negedge clock);
                cyc++;
            end
        end
        start = 1'b0;
        checks++;
        if (!seen || cyc != 171) begin
            failures++;
            $display("FAIL pass_len got=%0d exp=171 (done seen=%0d)", cyc, seen);
        end
        checks++;
        if (p != exp_q.size()) begin
            failures++;
            $display("FAIL pixel_count got=%0d exp=%0d", p, exp_q.size());
        end
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || plot !== 1'b0) begin
            failures++;
            $display("FAIL post_pass got busy=%b done=%b plot=%b exp=000", busy, done, plot);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({busy, done, bounce, plot, overrun} !== 5'b0 || {x, y, colour} !== 19'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b/%h exp=0/0", {busy, done, bounce, plot, overrun},
                     {x, y, colour});
        end
        checks++;
        if (blocks_left !== 3'd5) begin
            failures++;
            $display("FAIL reset_blocks_left got=%0d exp=5", blocks_left);
        end
    endtask

    task automatic test_idle_pass();
        int b;
        do_reset();
        run_pass(0, 0, 1'b0, 0, b);
        checks++;
        if (b != 0) begin
            failures++;
            $display("FAIL idle_pass_bounce got=%0d exp=0", b);
        end
    endtask

    task automatic test_hits();
        int b;
        do_reset();
        for (int n = 0; n < 4; n++) begin
            run_pass(18, 31, 1'b0, 0, b);
            checks++;
            if (b != ((n < 3) ? 1 : 0)) begin
                failures++;
                $display("FAIL hit_pass%0d got=%0d exp=%0d", n, b, (n < 3) ? 1 : 0);
            end
        end
        checks++;
        if (blocks_left !== 3'd4) begin
            failures++;
            $display("FAIL hits_blocks_left got=%0d exp=4", blocks_left);
        end
    endtask

    task automatic test_boundary();
        int bx_t [4] = '{22, 23, 22, 15};
        int by_t [4] = '{30, 30, 32, 30};
        int hb_t [4] = '{1, 0, 0, 1};
        int b;
        do_reset();
        for (int n = 0; n < 4; n++) begin
            run_pass(bx_t[n], by_t[n], 1'b0, 0, b);
            checks++;
            if (b != hb_t[n]) begin
                failures++;
                $display("FAIL boundary(%0d,%0d) got=%0d exp=%0d", bx_t[n], by_t[n], b, hb_t[n]);
            end
        end
    endtask

    task automatic test_lower();
        int b;
        do_reset();
        for (int n = 0; n < 3; n++) run_pass(48, 30, 1'b0, 0, b);
        for (int n = 0; n < 8; n++) begin
            run_pass(0, 0, 1'b1, 0, b);
            checks++;
            if (overrun !== ((n == 7) ? 1'b1 : 1'b0)) begin
                failures++;
                $display("FAIL lower_overrun pass=%0d got=%b exp=%0d", n, overrun, n == 7);
            end
        end
    endtask

    task automatic test_back_to_back();
        int b;
        do_reset();
        run_pass(0, 0, 1'b0, 20, b);
        run_pass(0, 0, 1'b0, 0, b);
    endtask

    task automatic test_reset_mid();
        int b;
        do_reset();
        @(negedge clock);
        ball_x = 8'd18;
        ball_y = 8'd31;
        lower = 1'b1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int c = 1; c < 50; c++) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({busy, done, bounce, plot} !== 4'b0 || blocks_left !== 3'd5) begin
            failures++;
            $display("FAIL reset_mid got bdbp=%b left=%0d exp=0000 left=5",
                     {busy, done, bounce, plot}, blocks_left);
        end
        reset = 1'b0;
        model_reset();
        run_pass(0, 0, 1'b0, 0, b);
    endtask

    task automatic test_random();
        int i, b;
        do_reset();
        for (int n = 0; n < 25; n++) begin
            i = int'($urandom_range(0, 4));
            run_pass(15 + 30 * i + int'($urandom_range(0, 10)) - 1,
                     m_y[i] + int'($urandom_range(0, 3)) - 1,
                     $urandom_range(0, 3) == 0, 0, b);
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        lower = 1'b0;
        ball_x = 8'd0;
        ball_y = 8'd0;
        model_reset();
        test_reset();
        test_idle_pass();
        test_hits();
        test_boundary();
        test_lower();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
